// File: rtl/sha_pkg.sv
// Shared types and width constants for the SHA job controller slice.
package sha_pkg;

  localparam int MIDSTATE_W = 256;
  localparam int HEAD_W     = 512;
  localparam int NONCE_W    = 32;
  localparam int SWEEP_W    = 40;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SOLVE  = 2'd2,
    REPORT = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/sha_sweep_timer.sv
// Solve-phase timing: 40-bit sweep counter for nonce-space exhaustion and a
// short saturating counter that masks flag while the solve pipeline fills.
module sha_sweep_timer
  import sha_pkg::*;
#(
  parameter logic [SWEEP_W-1:0] SWEEP_CYCLES     = 40'd137438953472,
  parameter int                 FLAG_MASK_CYCLES = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_done,
  output logic o_masked
);

  localparam logic [3:0] MASK_LIMIT = 4'(FLAG_MASK_CYCLES);

  logic [SWEEP_W-1:0] r_sweep_cnt;
  logic [3:0]         r_mask_cnt;

  always_ff @(posedge clk) begin
    if (!n_rst || i_clear) begin
      r_sweep_cnt <= '0;
      r_mask_cnt  <= '0;
    end else if (i_en) begin
      r_sweep_cnt <= r_sweep_cnt + 1'b1;
      // Saturates so a long solve never re-opens the mask window.
      if (r_mask_cnt < MASK_LIMIT) begin
        r_mask_cnt <= r_mask_cnt + 1'b1;
      end
    end
  end

  assign o_done   = (r_sweep_cnt == (SWEEP_CYCLES - 1'b1));
  assign o_masked = (r_mask_cnt < MASK_LIMIT);

endmodule

// File: rtl/sha_job_controller.sv
// Job sequencer for the multi-core SHA solve block: accept a job, clear the
// counters, run the solve, and report found/exhausted/aborted to the host.
module sha_job_controller
  import sha_pkg::*;
#(
  parameter int                 NCORE            = 2,
  parameter logic [SWEEP_W-1:0] SWEEP_CYCLES     = SWEEP_W'(64 * (64'h1_0000_0000 / NCORE)),
  parameter int                 CLEAR_CYCLES     = 2,
  parameter int                 FLAG_MASK_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [MIDSTATE_W-1:0] job_midstate,
  input  logic [HEAD_W-1:0]     job_headdata,
  input  logic                  abort,
  output logic [MIDSTATE_W-1:0] midState,
  output logic [HEAD_W-1:0]     headData,
  output logic                  loadState,
  output logic                  solveEn,
  input  logic                  flag,
  input  logic [NONCE_W-1:0]    goldenNonce,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  result_found,
  output logic                  result_aborted,
  output logic [NONCE_W-1:0]    result_nonce,
  output logic                  busy
);

  localparam logic [3:0] CLEAR_LAST = 4'(CLEAR_CYCLES - 1);

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;

  logic [3:0]            r_clr_cnt;
  logic [MIDSTATE_W-1:0] r_midstate;
  logic [HEAD_W-1:0]     r_headdata;
  logic                  r_found;
  logic                  r_aborted;
  logic [NONCE_W-1:0]    r_nonce;

  logic w_in_solve;
  logic w_done;
  logic w_masked;
  logic w_hit;
  logic w_exit;
  logic w_accept;

  assign w_in_solve = (r_state == SOLVE);
  assign w_hit      = flag && !w_masked;
  assign w_exit     = w_in_solve && (abort || w_hit || w_done);
  assign w_accept   = (r_state == IDLE) && job_valid;

  // Counters sit at zero outside SOLVE, so the first SOLVE cycle sees count 0.
  sha_sweep_timer #(
    .SWEEP_CYCLES     (SWEEP_CYCLES),
    .FLAG_MASK_CYCLES (FLAG_MASK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_clear  (!w_in_solve),
    .i_en     (w_in_solve),
    .o_done   (w_done),
    .o_masked (w_masked)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (job_valid)                w_state_next = CLEAR;
      CLEAR:   if (r_clr_cnt == CLEAR_LAST)  w_state_next = SOLVE;
      SOLVE:   if (w_exit)                   w_state_next = REPORT;
      REPORT:  if (result_ready)             w_state_next = IDLE;
      default:                               w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_clr_cnt  <= '0;
      r_midstate <= '0;
      r_headdata <= '0;
      r_found    <= 1'b0;
      r_aborted  <= 1'b0;
      r_nonce    <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_midstate <= job_midstate;
        r_headdata <= job_headdata;
        r_clr_cnt  <= '0;
      end else if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end

      // Exit priority: abort, then unmasked flag, then exhaustion.
      if (w_exit) begin
        if (abort) begin
          r_found   <= 1'b0;
          r_aborted <= 1'b1;
          r_nonce   <= '0;
        end else if (w_hit) begin
          r_found   <= 1'b1;
          r_aborted <= 1'b0;
          r_nonce   <= goldenNonce;
        end else begin
          r_found   <= 1'b0;
          r_aborted <= 1'b0;
          r_nonce   <= '0;
        end
      end
    end
  end

  assign job_ready      = (r_state == IDLE);
  assign busy           = (r_state != IDLE);
  assign loadState      = w_in_solve;
  assign solveEn        = w_in_solve;
  assign result_valid   = (r_state == REPORT);
  assign result_found   = r_found;
  assign result_aborted = r_aborted;
  assign result_nonce   = r_nonce;
  assign midState       = r_midstate;
  assign headData       = r_headdata;

endmodule

// File: tb/tb_sha_job_controller.sv
// Randomized bench for sha_job_controller; each job's outcome is predicted by
// scanning per-cycle flag/abort plans against the documented exit rules.
module tb_sha_job_controller;

  localparam int SWEEP = 100;
  localparam int CLRC  = 2;
  localparam int MASK  = 3;
  localparam int PLAN  = 128;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_midstate;
  logic [511:0] job_headdata;
  logic         abort;
  logic [255:0] midState;
  logic [511:0] headData;
  logic         loadState;
  logic         solveEn;
  logic         flag;
  logic [31:0]  goldenNonce;
  logic         result_valid;
  logic         result_ready;
  logic         result_found;
  logic         result_aborted;
  logic [31:0]  result_nonce;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  bit          flag_v  [PLAN];
  bit          abort_v [PLAN];
  logic [31:0] nonce_v [PLAN];
  logic [255:0] job_ms;
  logic [511:0] job_hd;

  int          exp_len;
  bit          exp_found;
  bit          exp_aborted;
  logic [31:0] exp_nonce;

  sha_job_controller #(
    .NCORE            (2),
    .SWEEP_CYCLES     (40'd100),
    .CLEAR_CYCLES     (CLRC),
    .FLAG_MASK_CYCLES (MASK)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_midstate   (job_midstate),
    .job_headdata   (job_headdata),
    .abort          (abort),
    .midState       (midState),
    .headData       (headData),
    .loadState      (loadState),
    .solveEn        (solveEn),
    .flag           (flag),
    .goldenNonce    (goldenNonce),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_found   (result_found),
    .result_aborted (result_aborted),
    .result_nonce   (result_nonce),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < PLAN; i++) begin
      flag_v[i]  = 1'b0;
      abort_v[i] = 1'b0;
      nonce_v[i] = $urandom;
    end
  endtask

  task automatic rand_job();
    for (int i = 0; i < 8; i++)  job_ms[i*32 +: 32] = $urandom;
    for (int i = 0; i < 16; i++) job_hd[i*32 +: 32] = $urandom;
  endtask

  // Reference: walk solve cycles in order and stop at the first qualifying event.
  task automatic compute_expected();
    exp_len     = SWEEP;
    exp_found   = 1'b0;
    exp_aborted = 1'b0;
    exp_nonce   = 32'd0;
    for (int k = 0; k < SWEEP; k++) begin
      if (abort_v[k]) begin
        exp_aborted = 1'b1;
        exp_len     = k + 1;
        break;
      end
      if (flag_v[k] && k >= MASK) begin
        exp_found = 1'b1;
        exp_nonce = nonce_v[k];
        exp_len   = k + 1;
        break;
      end
    end
  endtask

  task automatic run_job(input int hold, input string tag);
    int k;
    compute_expected();
    job_midstate = job_ms;
    job_headdata = job_hd;
    job_valid    = 1'b1;
    n_vec++;
    if (job_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s job_ready_idle: got %b want 1", tag, job_ready);
    end
    tick();
    job_valid    = 1'b0;
    job_midstate = ~job_ms;
    job_headdata = ~job_hd;
    n_vec++;
    if (midState !== job_ms || headData !== job_hd) begin
      n_err++;
      $display("FAIL %s job_latch: mid=%h want %h", tag, midState[31:0], job_ms[31:0]);
    end
    for (int i = 0; i < CLRC; i++) begin
      n_vec++;
      if (loadState !== 1'b0 || solveEn !== 1'b0 || job_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s clear_phase[%0d]: load=%b en=%b rdy=%b busy=%b want 0 0 0 1",
                 tag, i, loadState, solveEn, job_ready, busy);
      end
      tick();
    end
    k = 0;
    while (solveEn === 1'b1 && k < SWEEP + 4) begin
      flag        = flag_v[k];
      abort       = abort_v[k];
      goldenNonce = nonce_v[k];
      tick();
      k++;
    end
    flag  = 1'b0;
    abort = 1'b0;
    n_vec++;
    if (k !== exp_len) begin
      n_err++;
      $display("FAIL %s solve_len: got %0d want %0d", tag, k, exp_len);
    end
    for (int h = 0; h <= hold; h++) begin
      n_vec++;
      if (result_valid !== 1'b1 || result_found !== exp_found ||
          result_aborted !== exp_aborted || result_nonce !== exp_nonce ||
          job_ready !== 1'b0 || solveEn !== 1'b0 || loadState !== 1'b0) begin
        n_err++;
        $display("FAIL %s report[%0d]: v=%b f=%b a=%b n=%h rdy=%b en=%b want 1 %b %b %h 0 0",
                 tag, h, result_valid, result_found, result_aborted, result_nonce,
                 job_ready, solveEn, exp_found, exp_aborted, exp_nonce);
      end
      if (h < hold) begin
        abort = 1'($urandom_range(0, 1));
        tick();
        abort = 1'b0;
      end
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    n_vec++;
    if (result_valid !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0 || midState !== job_ms) begin
      n_err++;
      $display("FAIL %s handshake: v=%b rdy=%b busy=%b want 0 1 0", tag, result_valid, job_ready, busy);
    end
    $display("job %s: len=%0d found=%b aborted=%b nonce=%h", tag, k, result_found, result_aborted, result_nonce);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick();
    tick();
    n_vec++;
    if (job_ready !== 1'b1 || busy !== 1'b0 || loadState !== 1'b0 || solveEn !== 1'b0 ||
        result_valid !== 1'b0 || result_found !== 1'b0 || result_aborted !== 1'b0 ||
        result_nonce !== 32'd0 || midState !== 256'd0 || headData !== 512'd0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b busy=%b load=%b en=%b v=%b n=%h", job_ready, busy,
               loadState, solveEn, result_valid, result_nonce);
    end
    n_rst = 1'b1;
    tick();
    $display("reset: checked reset values");
  endtask

  task automatic test_found_basic();
    clear_plan();
    job_ms = {32{8'hA5}};
    for (int i = 0; i < 16; i++) job_hd[i*32 +: 32] = $urandom;
    flag_v[10]  = 1'b1;
    nonce_v[10] = 32'h1234ABCD;
    run_job(0, "found_basic");
  endtask

  task automatic test_exhaust();
    clear_plan();
    rand_job();
    run_job(1, "exhaust");
  endtask

  task automatic test_mask();
    clear_plan();
    rand_job();
    for (int i = 0; i <= 3; i++) flag_v[i] = 1'b1;
    run_job(0, "mask");
    clear_plan();
    rand_job();
    flag_v[SWEEP-1] = 1'b1;
    run_job(0, "flag_at_exhaust");
  endtask

  task automatic test_abort();
    clear_plan();
    rand_job();
    flag_v[5]  = 1'b1;
    abort_v[5] = 1'b1;
    run_job(2, "abort_flag");
    for (int i = 0; i < 3; i++) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_vec++;
      if (job_ready !== 1'b1 || busy !== 1'b0 || solveEn !== 1'b0 || result_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort_idle[%0d]: rdy=%b busy=%b en=%b v=%b", i, job_ready, busy, solveEn, result_valid);
      end
    end
    $display("abort_idle: checked 3 cycles");
  endtask

  task automatic test_hold_back_to_back();
    clear_plan();
    rand_job();
    flag_v[20] = 1'b1;
    run_job(20, "hold20");
    clear_plan();
    rand_job();
    flag_v[7] = 1'b1;
    run_job(0, "back_to_back");
  endtask

  task automatic test_reset_mid_solve();
    rand_job();
    job_midstate = job_ms;
    job_headdata = job_hd;
    job_valid    = 1'b1;
    tick();
    job_valid = 1'b0;
    for (int i = 0; i < CLRC + 3; i++) tick();
    n_vec++;
    if (solveEn !== 1'b1) begin
      n_err++;
      $display("FAIL mid_solve_entry: en=%b want 1", solveEn);
    end
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    n_vec++;
    if (solveEn !== 1'b0 || loadState !== 1'b0 || result_valid !== 1'b0 ||
        job_ready !== 1'b1 || busy !== 1'b0 || midState !== 256'd0) begin
      n_err++;
      $display("FAIL reset_mid_solve: en=%b load=%b v=%b rdy=%b busy=%b", solveEn, loadState,
               result_valid, job_ready, busy);
    end
    $display("reset_mid_solve: checked");
  endtask

  task automatic test_random();
    int mode;
    for (int j = 0; j < 16; j++) begin
      clear_plan();
      rand_job();
      mode = $urandom_range(0, 3);
      case (mode)
        1: for (int i = 0; i < PLAN; i++) flag_v[i] = ($urandom_range(0, 15) == 0);
        2: begin
          for (int i = 0; i < PLAN; i++) flag_v[i] = ($urandom_range(0, 31) == 0);
          abort_v[$urandom_range(0, SWEEP-1)] = 1'b1;
        end
        3: for (int i = 0; i < MASK; i++) flag_v[i] = 1'b1;
        default: ;
      endcase
      run_job($urandom_range(0, 5), $sformatf("rand%0d_m%0d", j, mode));
    end
  endtask

  initial begin
    n_rst        = 1'b0;
    job_valid    = 1'b0;
    job_midstate = '0;
    job_headdata = '0;
    abort        = 1'b0;
    flag         = 1'b0;
    goldenNonce  = '0;
    result_ready = 1'b0;
    #1;
    test_reset();
    test_found_basic();
    test_exhaust();
    test_mask();
    test_abort();
    test_hold_back_to_back();
    test_reset_mid_solve();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha_job_controller.md
Name: sha_job_controller

Overview:
- Sequences the multi-core SHA solve block: accepts one mining job (midstate + header block) over a valid/ready handshake, latches it, clears the cycle/nonce counters, and enables solving.
- Monitors the solve block's flag/golden nonce, stops on a hit, nonce-space exhaustion or abort, and reports the outcome over a valid/ready result handshake.
- Sits between the host/UART job interface and the SHA solve block.

Parameters:
- NCORE, 2, number of SHA cores in the solve block; used only to size the default sweep length.
- SWEEP_CYCLES, 64*((2^32)/NCORE), solve cycles covering the full nonce space; must fit in 40 bits.
- CLEAR_CYCLES, 2, cycles loadState is held low to clear the counters (range 1..15).
- FLAG_MASK_CYCLES, 3, solve cycles after solveEn rises during which flag is ignored (pipeline and output-manager latency; range 0..15).

Ports:
- clk  in  1  system clock
- n_rst  in  1  synchronous active-low reset
- job_valid  in  1  new job offered
- job_ready  out  1  controller accepts job this cycle
- job_midstate  in  256  midstate of job
- job_headdata  in  512  second header block of job
- abort  in  1  one-cycle request to drop current job
- midState  out  256  latched midstate to solve block
- headData  out  512  latched header block to solve block
- loadState  out  1  low = counters cleared; high = counters run
- solveEn  out  1  enable for cycle counter and output manager
- flag  in  1  solve block hit indication
- goldenNonce  in  32  nonce from solve block, valid with flag
- result_valid  out  1  result available
- result_ready  in  1  consumer takes result
- result_found  out  1  1 = nonce found, 0 = space exhausted or aborted
- result_aborted  out  1  1 = job terminated by abort
- result_nonce  out  32  golden nonce when result_found, else 0
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock is clk; reset is n_rst, synchronous and active-low. All state updates occur on the rising clk edge.
- Reset values: state IDLE, job_ready 1, loadState 0, solveEn 0, result_valid 0, result_found 0, result_aborted 0, result_nonce 0, midState 0, headData 0, busy 0, all counters 0.
- IDLE:
  - job_ready=1.
  - On job_valid&job_ready: latch job_midstate/job_headdata into midState/headData, clear the sweep and mask counters, go to CLEAR.
  - abort in IDLE is ignored.
- CLEAR:
  - loadState=0, solveEn=0, job_ready=0.
  - Stays exactly CLEAR_CYCLES cycles (4-bit counter), then goes to SOLVE.
- SOLVE:
  - loadState=1, solveEn=1.
  - A 40-bit sweep counter increments every cycle, starting at 0 on the first SOLVE cycle.
  - A mask counter runs for the first FLAG_MASK_CYCLES cycles; flag is ignored while masked.
  - Exit priority, highest first:
    - abort: result_found=0, result_aborted=1, result_nonce=0.
    - unmasked flag: result_found=1, result_aborted=0, result_nonce=goldenNonce sampled the same cycle.
    - sweep counter == SWEEP_CYCLES-1: result_found=0, result_aborted=0, result_nonce=0.
  - On any exit: go to REPORT with result_valid=1 from the next cycle; solveEn=0 and loadState=0 in REPORT.
- REPORT:
  - result_valid=1; result fields are held stable until the handshake.
  - On result_valid&result_ready: result_valid=0, go to IDLE; job_ready=1 from the next cycle.
  - abort is ignored.
- Simultaneous events:
  - flag and exhaustion on the same cycle: found wins.
  - abort and flag on the same cycle: abort wins.
  - Any unmasked flag always exits SOLVE; there is no scan continuation.
- Job outputs:
  - midState/headData change only on job acceptance.
  - They hold through REPORT and IDLE until the next job is accepted.
- Reset mid-operation: from any state, return to the reset values on the next edge. Any pending result is dropped.
- Latency:
  - Job accept to first solveEn=1: CLEAR_CYCLES+1 cycles.
  - Qualifying flag to result_valid: 1 cycle.

Decomposition:
- Shared package sha_pkg holds:
  - typedef ctrl_state_t {IDLE, CLEAR, SOLVE, REPORT};
  - the width constants MIDSTATE_W=256, HEAD_W=512, NONCE_W=32, SWEEP_W=40.
- One natural sub-module, sha_sweep_timer: the 40-bit sweep counter plus the mask counter, with a clear input and done/masked outputs.
- The FSM and the job/result registers stay in sha_job_controller.

Test Plan:
- Reset mid-SOLVE (n_rst=0 for one cycle) -> next cycle state IDLE, solveEn=0, loadState=0, result_valid=0, job_ready=1.
- Job with midstate=0xA5..A5 accepted at cycle t, flag=1 with goldenNonce=0x1234ABCD at SOLVE cycle 10 -> loadState low at t+1..t+2, solveEn=1 from t+3; result_valid=1, result_found=1, result_nonce=0x1234ABCD one cycle after the flag.
- SWEEP_CYCLES=100 and flag never asserted -> exactly 100 cycles with solveEn=1, then result_found=0, result_aborted=0, result_nonce=0.
- flag=1 on SOLVE cycles 0..2 with FLAG_MASK_CYCLES=3 -> no exit; flag=1 on cycle 3 -> found with that cycle's goldenNonce.
- abort and flag on the same SOLVE cycle -> result_aborted=1, result_found=0; separately, abort asserted in IDLE -> no state change.
- Hold result_ready=0 for 20 cycles in REPORT -> result fields stable and job_ready=0 throughout; result_ready=1 -> IDLE next cycle; a back-to-back job_valid is accepted the following cycle.
